// File: rtl/mmix_mem_responder.sv
// mmix_mem_responder: sized big-endian MMIX data accesses -> 64-bit Avalon-MM master, one transfer at a time.
// Optional one-octa read buffer is enabled by defining MMIX_MEMRESP_RDBUF_EN.
module mmix_mem_responder #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       mem_address,
    input  logic [1:0]        mem_datasize,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [63:0]       mem_writedata,
    output logic [63:0]       mem_readdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] avm_address,
    output logic [7:0]        avm_byteenable,
    output logic              avm_read,
    output logic              avm_write,
    output logic [63:0]       avm_writedata,
    input  logic [63:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP} state_t;
    state_t state, state_next;

    logic [3:0]  req_nb;
    logic [2:0]  req_off;
    logic [2:0]  req_lsh;
    logic [7:0]  req_be_base;
    logic [7:0]  req_be;
    logic [63:0] req_wdata;
    logic [2:0]  lsh;
    logic [1:0]  size;
    logic        accept;
    logic        rd_done;
    logic        wr_done;
    logic        buf_hit;
    logic        unused_addr_hi;

    // Pull the addressed bytes down from their lanes and zero the rest.
    function automatic logic [63:0] extract(input logic [63:0] octa, input logic [2:0] sh,
                                            input logic [1:0] sz);
        logic [63:0] s;
        s = octa >> {sh, 3'b000};
        case (sz)
            2'd0:    extract = {56'd0, s[7:0]};
            2'd1:    extract = {48'd0, s[15:0]};
            2'd2:    extract = {32'd0, s[31:0]};
            default: extract = s;
        endcase
    endfunction

    // Low address bits inside the access size are dropped; lane shift is 8-nb-off.
    assign req_nb    = 4'd1 << mem_datasize;
    assign req_off   = mem_address[2:0] & ~(req_nb[2:0] - 3'd1);
    assign req_lsh   = 3'(4'd8 - req_nb - {1'b0, req_off});
    assign req_wdata = mem_writedata << {req_lsh, 3'b000};
    assign req_be    = req_be_base << req_lsh;

    always_comb begin
        case (mem_datasize)
            2'd0:    req_be_base = 8'h01;
            2'd1:    req_be_base = 8'h03;
            2'd2:    req_be_base = 8'h0F;
            default: req_be_base = 8'hFF;
        endcase
    end

    assign unused_addr_hi = ^mem_address[63:ADDR_W];

    assign accept  = (state == IDLE) && (mem_read || mem_write);
    assign rd_done = avm_readdatavalid &&
                     ((state == RD_WAIT) || ((state == RD_ISSUE) && !avm_waitrequest));
    assign wr_done = (state == WR_ISSUE) && !avm_waitrequest;

`ifdef MMIX_MEMRESP_RDBUF_EN
    logic              buf_valid;
    logic [ADDR_W-4:0] buf_tag;
    logic [63:0]       buf_data;
    logic [63:0]       buf_merged;

    assign buf_hit = buf_valid && (buf_tag == mem_address[ADDR_W-1:3]);

    always_comb begin
        buf_merged = buf_data;
        for (int i = 0; i < 8; i++)
            if (avm_byteenable[i]) buf_merged[8*i +: 8] = avm_writedata[8*i +: 8];
    end

    // Stores to the buffered octa are merged so later hits see the new bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (rd_done) begin
            buf_valid <= 1'b1;
            buf_tag   <= avm_address[ADDR_W-1:3];
            buf_data  <= avm_readdata;
        end else if (wr_done && buf_valid && (buf_tag == avm_address[ADDR_W-1:3])) begin
            buf_data  <= buf_merged;
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_write)     state_next = WR_ISSUE;
                else if (mem_read) state_next = buf_hit ? RESP : RD_ISSUE;
            end
            RD_ISSUE: if (!avm_waitrequest) state_next = avm_readdatavalid ? RESP : RD_WAIT;
            RD_WAIT:  if (avm_readdatavalid) state_next = RESP;
            WR_ISSUE: if (!avm_waitrequest) state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            mem_done       <= 1'b0;
            mem_readdata   <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
            lsh            <= '0;
            size           <= '0;
        end else begin
            state     <= state_next;
            mem_done  <= (state_next == RESP);
            avm_read  <= (state_next == RD_ISSUE);
            avm_write <= (state_next == WR_ISSUE);
            if (accept) begin
                avm_address    <= {mem_address[ADDR_W-1:3], 3'b000};
                avm_byteenable <= req_be;
                lsh            <= req_lsh;
                size           <= mem_datasize;
                if (mem_write) avm_writedata <= req_wdata;
            end
            if (rd_done)      mem_readdata <= extract(avm_readdata, lsh, size);
            else if (wr_done) mem_readdata <= '0;
`ifdef MMIX_MEMRESP_RDBUF_EN
            if (accept && !mem_write && buf_hit)
                mem_readdata <= extract(buf_data, req_lsh, mem_datasize);
`endif
        end
    end
endmodule

// File: tb/tb_mmix_mem_responder.sv
// Bench for mmix_mem_responder: vector table plus scoreboard against a small Avalon RAM model.
module tb_mmix_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] mem_address;
    logic [1:0]  mem_datasize;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_writedata;
    logic [63:0] mem_readdata;
    logic        mem_done;
    logic [31:0] avm_address;
    logic [7:0]  avm_byteenable;
    logic        avm_read;
    logic        avm_write;
    logic [63:0] avm_writedata;
    logic [63:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;

    mmix_mem_responder #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .mem_address(mem_address), .mem_datasize(mem_datasize),
        .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_done(mem_done),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 clk = ~clk;

`ifdef MMIX_MEMRESP_RDBUF_EN
    localparam int HL = 1, HB = 0;
`else
    localparam int HL = 3, HB = 1;
`endif

    typedef struct {
        bit          wr;
        logic [1:0]  sz;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          wt;
        int          rl;
        logic [31:0] eaddr;
        logic [7:0]  ebe;
        logic [63:0] ewdata;
        logic [63:0] erdata;
        int          elat;
        int          ebus;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t vecs[11];

    // Slave model state
    logic [63:0] ram[logic [28:0]];
    int          cfg_wait = 0;
    int          cfg_rlat = 1;
    int          wait_left = 0;
    int          rdv_cnt = 0;
    logic [63:0] rdv_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Avalon slave: reacts #1 after each edge to the freshly registered master outputs.
    always @(posedge clk) begin
        logic [63:0] tmp;
        #1;
        avm_readdatavalid = 1'b0;
        if (rdv_cnt > 0) begin
            rdv_cnt--;
            if (rdv_cnt == 0) avm_readdatavalid = 1'b1;
        end
        if (!(avm_read || avm_write)) begin
            wait_left = cfg_wait;
            avm_waitrequest = 1'b0;
        end else if (wait_left > 0) begin
            avm_waitrequest = 1'b1;
            wait_left--;
        end else begin
            avm_waitrequest = 1'b0;
            wait_left = cfg_wait;
            if (avm_write) begin
                tmp = ram[avm_address[31:3]];
                for (int i = 0; i < 8; i++)
                    if (avm_byteenable[i]) tmp[8*i +: 8] = avm_writedata[8*i +: 8];
                ram[avm_address[31:3]] = tmp;
            end else begin
                rdv_data = ram[avm_address[31:3]];
                if (cfg_rlat == 0) avm_readdatavalid = 1'b1;
                else rdv_cnt = cfg_rlat;
            end
        end
        avm_readdata = avm_readdatavalid ? rdv_data : 64'hDEAD_BEEF_0BAD_F00D;
    end

    // Scoreboard: bus fields at the accept cycle, load data at mem_done.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if ((avm_read || avm_write) && !avm_waitrequest) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected actual=addr %h required=no transfer", avm_address);
                end else begin
                    e = exp_q[0];
                    chk("bus_cmd", avm_write, e.wr);
                    chk("bus_addr", avm_address, e.addr);
                    chk("bus_be", avm_byteenable, e.be);
                    if (avm_write) chk("bus_wdata", avm_writedata, e.wdata);
                end
            end
            if (mem_done) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected actual=done required=no done");
                end else begin
                    e = exp_q.pop_front();
                    chk("readdata", mem_readdata, e.rdata);
                end
            end
        end
    end

    task automatic wait_done(output int lat, output int bus);
        bit got;
        lat = 0; bus = 0; got = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (avm_read || avm_write) bus++;
            if (mem_done) begin
                got = 1;
                break;
            end
            lat++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=no done required=done within 50 cycles");
        end
    endtask

    // Called at a negedge; request goes out in the following cycle.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int   lat, bus;
        cfg_wait = v.wt;
        cfg_rlat = v.rl;
        @(posedge clk); #1;
        mem_write = v.wr; mem_read = !v.wr; mem_datasize = v.sz;
        mem_address = v.addr; mem_writedata = v.wdata;
        e.wr = v.wr; e.addr = v.eaddr; e.be = v.ebe; e.wdata = v.ewdata; e.rdata = v.erdata;
        exp_q.push_back(e);
        wait_done(lat, bus);
        mem_read = 0; mem_write = 0;
        chk("latency", lat, v.elat);
        chk("bus_cycles", bus, v.ebus);
        @(negedge clk);
        chk("done_pulse", mem_done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        vec_t v;
        int   lat, bus, bad;

        //           wr  sz  addr                    wdata               wt rl eaddr     be     ewdata                 erdata                 lat bus
        vecs[0]  = '{1, 3, 64'h100,                64'h0123456789ABCDEF, 0, 1, 32'h100, 8'hFF, 64'h0123456789ABCDEF, 64'h0,                 2, 1};
        vecs[1]  = '{0, 0, 64'h103,                64'h0,                0, 1, 32'h100, 8'h10, 64'h0,                 64'h67,                3, 1};
        vecs[2]  = '{1, 1, 64'h10B,                64'hBEEF,             0, 1, 32'h108, 8'h30, 64'h0000BEEF00000000, 64'h0,                 2, 1};
        vecs[3]  = '{0, 3, 64'h10F,                64'h0,                0, 1, 32'h108, 8'hFF, 64'h0,                 64'h1122BEEF55667788, 3, 1};
        vecs[4]  = '{0, 2, 64'h104,                64'h0,                3, 2, 32'h100, 8'h0F, 64'h0,                 64'h89ABCDEF,          7, 4};
        vecs[5]  = '{1, 0, 64'h207,                64'h5A,               2, 1, 32'h200, 8'h01, 64'h5A,                64'h0,                 4, 3};
        vecs[6]  = '{0, 1, 64'h206,                64'h0,                0, 0, 32'h200, 8'h03, 64'h0,                 64'h325A,              2, 1};
        vecs[7]  = '{0, 0, 64'h200,                64'h0,                0, 1, 32'h200, 8'h80, 64'h0,                 64'hFE,               HL, HB};
        vecs[8]  = '{1, 2, 64'h202,                64'hCAFEF00D,         0, 1, 32'h200, 8'hF0, 64'hCAFEF00D00000000, 64'h0,                 2, 1};
        vecs[9]  = '{0, 3, 64'h200,                64'h0,                0, 1, 32'h200, 8'hFF, 64'h0,                 64'hCAFEF00D7654325A, HL, HB};
        vecs[10] = '{0, 0, 64'hABCD00000000010A,   64'h0,                0, 1, 32'h108, 8'h20, 64'h0,                 64'hBE,                3, 1};

        ram[29'h100 >> 3] = 64'h0123456789ABCDEF;
        ram[29'h108 >> 3] = 64'h1122334455667788;
        ram[29'h200 >> 3] = 64'hFEDCBA9876543210;

        reset = 1; mem_read = 0; mem_write = 0; mem_datasize = 0;
        mem_address = 0; mem_writedata = 0;
        avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = 0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", {mem_done, avm_read, avm_write, avm_byteenable}, 0);
        chk("reset_data", mem_readdata | avm_writedata | {32'd0, avm_address}, 0);
        reset = 0;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Repeat read of one octa, then a byte store into it and a re-read.
        v = '{0, 3, 64'h100, 64'h0, 0, 1, 32'h100, 8'hFF, 64'h0, 64'h0123456789ABCDEF, 3, 1};
        run_vec(v);
        v.elat = HL; v.ebus = HB;
        run_vec(v);
        v = '{1, 0, 64'h100, 64'hAA, 0, 1, 32'h100, 8'h80, 64'hAA00000000000000, 64'h0, 2, 1};
        run_vec(v);
        v = '{0, 3, 64'h100, 64'h0, 0, 1, 32'h100, 8'hFF, 64'h0, 64'hAA23456789ABCDEF, HL, HB};
        run_vec(v);

        // Request held high through RESP must not start a second transfer.
        cfg_wait = 0; cfg_rlat = 1;
        @(posedge clk); #1;
        mem_write = 1; mem_datasize = 0; mem_address = 64'h10F; mem_writedata = 64'h77;
        e.wr = 1; e.addr = 32'h108; e.be = 8'h01; e.wdata = 64'h77; e.rdata = 64'h0;
        exp_q.push_back(e);
        wait_done(lat, bus);
        chk("hold_latency", lat, 2);
        @(posedge clk); #1;
        mem_write = 0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (avm_write || mem_done) bad++;
        end
        chk("hold_no_resample", bad, 0);

        // Request dropped and changed right after accept: original transfer completes.
        cfg_wait = 2; cfg_rlat = 1;
        @(posedge clk); #1;
        mem_read = 1; mem_datasize = 3; mem_address = 64'h108;
        e.wr = 0; e.addr = 32'h108; e.be = 8'hFF; e.wdata = 64'h0; e.rdata = 64'h1122BEEF55667777;
        exp_q.push_back(e);
        @(posedge clk); #1;
        mem_read = 0; mem_address = 64'h200; mem_datasize = 0;
        wait_done(lat, bus);
        chk("drop_latency", lat, 4);
        @(negedge clk);
        chk("drop_done_pulse", mem_done, 0);

        // Reset while waiting for read data; the late readdatavalid must be ignored.
        cfg_wait = 0; cfg_rlat = 3;
        @(posedge clk); #1;
        mem_read = 1; mem_datasize = 3; mem_address = 64'h100;
        e.wr = 0; e.addr = 32'h100; e.be = 8'hFF; e.wdata = 64'h0; e.rdata = 64'h0;
        exp_q.push_back(e);
        @(negedge clk);
        @(negedge clk);
        chk("rst_read_issued", avm_read, 1);
        @(posedge clk); #1;
        reset = 1; mem_read = 0;
        @(negedge clk);
        chk("rst_mid_ctl", {mem_done, avm_read, avm_write, avm_byteenable}, 0);
        chk("rst_mid_data", mem_readdata | avm_writedata | {32'd0, avm_address}, 0);
        @(posedge clk); #1;
        reset = 0;
        exp_q.delete();
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_done || avm_read || avm_write || (mem_readdata != 0)) bad++;
        end
        chk("rst_late_rdv_ignored", bad, 0);

        v = '{0, 0, 64'h108, 64'h0, 0, 1, 32'h108, 8'h80, 64'h0, 64'h11, 3, 1};
        run_vec(v);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
